gdiv_controller: RTL and testbench

- Sequencer for the two-stage Goldschmidt divide datapath (k generator + operand mux/flops, then CSAM multiplier + product flop). Sits directly upstream of it.
- Accepts a divide request and captures operands plus the initial reciprocal approximation.
- Drives the datapath's kSelect/ndSelect every cycle for ITERS iterations, captures the final numerator product from the datapath result, and presents it on a valid/ready output handshake.
- Also flags divide-by-zero without running the datapath.

---
 rtl/gdiv_controller.sv | 138 +++++++++++++
 tb/tb_gdiv_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gdiv_controller.sv
// Sequencer for the two-stage Goldschmidt divide datapath: issues D/N operand pairs
// for ITERS iterations, captures the final N product and hands it out on a valid/ready port.
module gdiv_controller #(
  parameter int ITERS = 3,
  parameter int CW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] n_in,
  input  logic [15:0] d_in,
  input  logic [15:0] ia_in,
  output logic        busy,
  output logic [15:0] N,
  output logic [15:0] D,
  output logic [15:0] IA,
  output logic        kSelect,
  output logic        ndSelect,
  input  logic [31:0] dp_result,
  output logic [31:0] q,
  output logic        q_valid,
  input  logic        q_ready,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DISS = 3'd1,
    ST_NISS = 3'd2,
    ST_WAIT = 3'd3,
    ST_CAPT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   n_r, d_r, ia_r;
  logic [31:0]   q_r;
  logic          q_valid_r, div_zero_r, busy_r, ksel_r, ndsel_r;

  // Select lines are registered from the next state/counter, so they equal the
  // combinational state decode while staying glitch-free at the outputs.
  // FSM, operand latches, quotient capture and select-line generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      n_r        <= 16'h0000;
      d_r        <= 16'h0000;
      ia_r       <= 16'h0000;
      q_r        <= 32'h0000_0000;
      q_valid_r  <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      ksel_r     <= 1'b0;
      ndsel_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            n_r    <= n_in;
            d_r    <= d_in;
            ia_r   <= ia_in;
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
            ksel_r <= 1'b0;
            if (d_in == 16'h0000) begin
              state_r    <= ST_DONE;
              q_r        <= 32'hFFFF_FFFF;
              div_zero_r <= 1'b1;
              q_valid_r  <= 1'b1;
              ndsel_r    <= 1'b1;
            end else begin
              state_r    <= ST_DISS;
              div_zero_r <= 1'b0;
              ndsel_r    <= 1'b0;
            end
          end
        end
        ST_DISS: begin
          state_r <= ST_NISS;
          ndsel_r <= 1'b1;
          ksel_r  <= 1'b0;
        end
        ST_NISS: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_WAIT;
            ndsel_r <= 1'b1;
            ksel_r  <= 1'b0;
          end else begin
            // Later iterations take k from the previous D product.
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= ST_DISS;
            ndsel_r <= 1'b0;
            ksel_r  <= 1'b1;
          end
        end
        ST_WAIT: begin
          state_r <= ST_CAPT;
        end
        ST_CAPT: begin
          q_r       <= dp_result;
          q_valid_r <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (q_valid_r && q_ready) begin
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= {CW{1'b0}};
          q_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          ksel_r    <= 1'b0;
          ndsel_r   <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign N        = n_r;
  assign D        = d_r;
  assign IA       = ia_r;
  assign kSelect  = ksel_r;
  assign ndSelect = ndsel_r;
  assign q        = q_r;
  assign q_valid  = q_valid_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_gdiv_controller.sv
// Scoreboard bench for gdiv_controller: a cycle-level Goldschmidt datapath model feeds
// dp_result, and a plain-arithmetic reference predicts each quotient.
module tb_gdiv_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b, q_ready_a, q_ready_b;
  logic [15:0] n_in, d_in, ia_in;
  logic        busy_a, ks_a, nd_a, qv_a, dz_a;
  logic        busy_b, ks_b, nd_b, qv_b, dz_b;
  logic [15:0] N_a, D_a, IA_a, N_b, D_b, IA_b;
  logic [31:0] dp_a, dp_b, q_a, q_b;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_a[$];
  logic [32:0] exp_b[$];

  always #5 clk = ~clk;

  gdiv_controller #(.ITERS(3), .CW(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .busy(busy_a), .N(N_a), .D(D_a), .IA(IA_a), .kSelect(ks_a), .ndSelect(nd_a),
    .dp_result(dp_a), .q(q_a), .q_valid(qv_a), .q_ready(q_ready_a), .div_zero(dz_a));

  gdiv_controller #(.ITERS(1), .CW(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .busy(busy_b), .N(N_b), .D(D_b), .IA(IA_b), .kSelect(ks_b), .ndSelect(nd_b),
    .dp_result(dp_b), .q(q_b), .q_valid(qv_b), .q_ready(q_ready_b), .div_zero(dz_b));

  // Reference quotient in Q2.14: k0 = IA, k_i = 2 - D_i; N and D both scaled by k each round.
  function automatic logic [32:0] ref_q(logic [15:0] n, logic [15:0] d, logic [15:0] ia, int iters);
    logic [15:0] nc, dc, k;
    logic [31:0] pn, pd;
    if (d == 16'h0000) return {1'b1, 32'hFFFF_FFFF};
    nc = n; dc = d; pn = 32'h0;
    for (int i = 0; i < iters; i++) begin
      k  = (i == 0) ? ia : 16'h8000 - dc;
      pd = 32'(dc) * 32'(k);
      pn = 32'(nc) * 32'(k);
      dc = pd[29:14];
      nc = pn[29:14];
    end
    return {1'b0, pn};
  endfunction

  // Datapath models: issue stage (k register, operand mux) then product register.
  logic [15:0] dk_a, dop_a, dk_b, dop_b;
  logic        dnf_a, dnf_b;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dk_a <= 16'h0; dop_a <= 16'h0; dnf_a <= 1'b0; dp_a <= 32'h0;
      dk_b <= 16'h0; dop_b <= 16'h0; dnf_b <= 1'b0; dp_b <= 32'h0;
    end else begin
      dp_a <= 32'(dop_a) * 32'(dk_a);
      if (!nd_a) begin
        dk_a  <= ks_a ? 16'h8000 - dp_a[29:14] : IA_a;
        dop_a <= ks_a ? dp_a[29:14] : D_a;
        dnf_a <= !ks_a;
      end else begin
        dop_a <= dnf_a ? N_a : dp_a[29:14];
        dnf_a <= 1'b0;
      end
      dp_b <= 32'(dop_b) * 32'(dk_b);
      if (!nd_b) begin
        dk_b  <= ks_b ? 16'h8000 - dp_b[29:14] : IA_b;
        dop_b <= ks_b ? dp_b[29:14] : D_b;
        dnf_b <= !ks_b;
      end else begin
        dop_b <= dnf_b ? N_b : dp_b[29:14];
        dnf_b <= 1'b0;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitors: pop the scoreboard on every accepted quotient.
  always @(negedge clk) begin
    if (reset && qv_a && q_ready_a) begin
      chk("a_result_expected", 64'(exp_a.size() != 0), 64'd1);
      if (exp_a.size() != 0) chk("a_q_dz", 64'({dz_a, q_a}), 64'(exp_a.pop_front()));
    end
    if (reset && qv_b && q_ready_b) begin
      chk("b_result_expected", 64'(exp_b.size() != 0), 64'd1);
      if (exp_b.size() != 0) chk("b_q_dz", 64'({dz_b, q_b}), 64'(exp_b.pop_front()));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_a(logic [15:0] n, logic [15:0] d, logic [15:0] ia);
    start_a = 1'b1; n_in = n; d_in = d; ia_in = ia;
    @(posedge clk);
    exp_a.push_back(ref_q(n, d, ia, 3));
    #1 start_a = 1'b0;
  endtask

  task automatic wait_valid_a(int budget);
    int c = 0;
    while (!qv_a && c < budget) begin
      cyc(1);
      c++;
    end
    chk("a_valid_within_budget", 64'(qv_a), 64'd1);
  endtask

  task automatic accept_a();
    q_ready_a = 1'b1;
    cyc(1);
    q_ready_a = 1'b0;
  endtask

  task automatic chk_reset_a();
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_nd_ia", 64'({N_a, D_a, IA_a}), 64'd0);
    chk("rst_q", 64'(q_a), 64'd0);
    chk("rst_qv_dz", 64'({qv_a, dz_a}), 64'd0);
    chk("rst_sel", 64'({nd_a, ks_a}), 64'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  seq_a[8];
    logic [1:0]  seq_b[4];
    logic [31:0] q0;
    logic        dz0;
    logic [15:0] rn, rd, ri;
    seq_a = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    seq_b = '{2'b00, 2'b10, 2'b10, 2'b10};
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; q_ready_a = 1'b0; q_ready_b = 1'b0;
    n_in = 16'h0; d_in = 16'h0; ia_in = 16'h0;
    #12;
    chk_reset_a();
    @(posedge clk); #1 reset = 1'b1;

    // Nominal sequence and latency, ITERS=3
    issue_a(16'h4000, 16'h6000, 16'h5555);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("seq_a_c%0d", c), 64'({nd_a, ks_a}), 64'(seq_a[c]));
      chk($sformatf("seq_a_qv_c%0d", c), 64'({qv_a, busy_a}), 64'b01);
      cyc(1);
    end
    chk("seq_a_qv_edge8", 64'(qv_a), 64'd1);

    // Back-pressure: outputs hold while q_ready low
    q0 = q_a; dz0 = dz_a;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      chk("hold_q", 64'({qv_a, dz_a, q_a}), 64'({1'b1, dz0, q0}));
    end
    accept_a();
    chk("after_accept", 64'({qv_a, busy_a}), 64'd0);

    // Divide by zero
    issue_a(16'h1111, 16'h0000, 16'h2222);
    chk("dz_qv_1edge", 64'({qv_a, dz_a, nd_a, busy_a}), 64'b1111);
    chk("dz_q", 64'(q_a), 64'hFFFF_FFFF);
    cyc(1);
    chk("dz_no_diss", 64'(nd_a), 64'd1);
    accept_a();

    // start ignored while busy (NISS and DONE)
    issue_a(16'h1234, 16'h3000, 16'h2AAB);
    cyc(1);
    start_a = 1'b1; n_in = 16'hAAAA; d_in = 16'h0000; ia_in = 16'h5555;
    cyc(1);
    start_a = 1'b0;
    chk("busy_ignore_niss", 64'({N_a, D_a, IA_a}), 64'({16'h1234, 16'h3000, 16'h2AAB}));
    wait_valid_a(20);
    start_a = 1'b1;
    cyc(1);
    start_a = 1'b0;
    chk("busy_ignore_done", 64'({qv_a, N_a, D_a, IA_a}), 64'({1'b1, 16'h1234, 16'h3000, 16'h2AAB}));
    accept_a();
    cyc(2);
    chk("single_result", 64'({qv_a, busy_a}), 64'd0);

    // Reset during DISS of iteration 1
    issue_a(16'h5000, 16'h5800, 16'h2E8C);
    cyc(2);
    chk("pre_reset_diss", 64'({nd_a, ks_a}), 64'b01);
    reset = 1'b0;
    #1;
    void'(exp_a.pop_back());
    chk_reset_a();
    @(posedge clk); #1 reset = 1'b1;
    issue_a(16'h3000, 16'h7000, 16'h2492);
    wait_valid_a(20);
    accept_a();

    // ITERS=1 build
    start_b = 1'b1; n_in = 16'h2468; d_in = 16'h8000; ia_in = 16'h2000;
    @(posedge clk);
    exp_b.push_back(ref_q(16'h2468, 16'h8000, 16'h2000, 1));
    #1 start_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("seq_b_c%0d", c), 64'({nd_b, ks_b, qv_b}), 64'({seq_b[c], 1'b0}));
      cyc(1);
    end
    chk("seq_b_qv_edge4", 64'({qv_b, ks_b}), 64'b10);
    q_ready_b = 1'b1;
    cyc(1);
    q_ready_b = 1'b0;
    chk("b_after_accept", 64'({qv_b, busy_b}), 64'd0);

    // Randomized divides with random back-pressure
    for (int i = 0; i < 30; i++) begin
      rn = 16'($urandom_range(16'h7FFF));
      rd = ($urandom_range(5) == 0) ? 16'h0000 : 16'($urandom_range(16'h7FFF, 16'h2000));
      ri = 16'($urandom_range(16'h7FFF, 16'h1000));
      issue_a(rn, rd, ri);
      wait_valid_a(20);
      cyc($urandom_range(3));
      accept_a();
    end

    cyc(3);
    chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
